titan_clint: RTL and testbench
==============================

# titan_clint

Machine-level core-local interruptor for the Titan core. Holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit. Exposes them as a Wishbone-classic slave and drives the timer and software interrupt lines into `titan_csr_exception_unit`. It is the source end of `xint_mtip_i` and `xint_msip_i`.

## Interface
Parameters:
- `TICK_DIV`, 1: `clk_i` cycles per `mtime` increment; legal range ≥1, 16-bit prescaler.
- `MTIME_RST`, 64'h0: reset value of `mtime`.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `wb_addr_i`  in  16  byte address offset within the CLINT window.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte lane enables.
- `wb_we_i`  in  1  write strobe.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_dat_o`  out  32  read data; 0 when not acking.
- `wb_ack_o`  out  1  one-cycle completion pulse.
- `wb_err_o`  out  1  one-cycle error pulse.
- `xint_mtip_o`  out  1  timer interrupt pending.
- `xint_msip_o`  out  1  software interrupt pending.

## Operation
- Register map, 32-bit words:
  - 0x0000 `msip`: bit0 is RW, bits 31:1 read 0.
  - 0x4000 / 0x4004 `mtimecmp` lo/hi.
  - 0xBFF8 / 0xBFFC `mtime` lo/hi.
- Request accepted when `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
- Mapped address with `wb_addr_i[1:0]==0` → `wb_ack_o` pulse; any other address → `wb_err_o` pulse, no state change, `wb_dat_o`=0.
- Writes are byte-lane masked by `wb_sel_i`. The write commits on the same edge that raises ack.
- Read data is registered and valid while ack is high.
- Prescaler counts 0..`TICK_DIV`-1. `mtime` increments on the cycle the prescaler wraps. `TICK_DIV`=1 gives an increment every cycle.
- `mtime` wraps 2^64-1 → 0 silently. No carry-out, no interrupt.
- Bus write to an `mtime` half in a tick cycle: the written half takes the written bytes and the increment is dropped for that cycle. Prescaler is unaffected.
- Hi and lo halves are independent. There is no shadow latch; software uses hi-lo-hi reads.
- `xint_mtip_o` is registered: `mtime >= mtimecmp`, unsigned 64-bit.
- `xint_msip_o` = `msip` bit0, straight from the flop.
- No state machine beyond the bus response flops, which have two states: IDLE and RESP. RESP lasts exactly one cycle, then returns to IDLE regardless of `wb_stb_i`. Back-to-back accesses therefore complete every 2 cycles.

## Timing
- Reset values:
  - `mtime`=`MTIME_RST`.
  - `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
  - `msip`=0, prescaler=0.
  - `wb_ack_o`=`wb_err_o`=0, `wb_dat_o`=0.
  - `xint_mtip_o`=0, `xint_msip_o`=0.
- Reset asserts asynchronously and clears everything immediately, including an in-flight ack. Release is synchronous to the next `clk_i` edge.
- Access latency: request sampled at edge N → ack/err high after edge N+1 → low after edge N+2.
- `msip` write: `xint_msip_o` changes at the edge that raises ack.
- `mtimecmp`/`mtime` write at edge N+1: `xint_mtip_o` reflects the new comparison after edge N+2.
- Counter reaching `mtimecmp` at edge K: `xint_mtip_o` rises after edge K+1. It stays high until `mtimecmp` is raised above `mtime`, or `mtime` is written or wraps below it.
- Request abandoned (`wb_stb_i` dropped) in the RESP cycle: the response still pulses and the write has already committed.

## Structure
- Constants belong in shared package `titan_clint_pkg`: the register offsets, the `mtimecmp` reset value and the prescaler width.
- One natural sub-module, `titan_clint_timer`: prescaler, 64-bit `mtime` with byte-masked write port and wrap, and the registered compare producing mtip.
- Bus decode, `msip` and `mtimecmp` live in the top.

## Test plan
- Reset, then idle 10 cycles with `TICK_DIV`=1 → `mtime` lo reads 10 ± access latency; mtip=0, msip=0.
- Write `mtimecmp`={0,20}, wait → `xint_mtip_o` rises exactly one cycle after `mtime`==20. Writing `mtimecmp` hi=1 drops mtip two cycles after the write is sampled.
- Write 0x0000 data=1 with sel=4'b0001 → `xint_msip_o`=1 on the ack edge. Then write data=0 with sel=4'b0000 → msip stays 1.
- Write `mtime` lo=32'hFFFF_FFFF, hi=32'hFFFF_FFFF with `mtimecmp` all ones → mtip=1. Next tick, `mtime` wraps to 0 and mtip falls after one cycle.
- Access 0x0002 and 0x1000 → `wb_err_o` pulse, no ack, no register change. Back-to-back legal reads → ack every second cycle.
- Assert `rst_ni` low mid-RESP → ack drops asynchronously; all registers return to reset values.

Source files
------------

// File: rtl/titan_clint_pkg.sv
// ---------------------------------------------------------------------------
// titan_clint_pkg
// Shared constants and helpers for the Titan core-local interruptor:
//   - register byte offsets inside the CLINT window
//   - reset value of mtimecmp and the prescaler width
//   - bus response state and register-select enumerations
//   - byte-lane merge and address decode helpers
// ---------------------------------------------------------------------------
package titan_clint_pkg;

    localparam logic [15:0] ADDR_MSIP        = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] ADDR_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] ADDR_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] ADDR_MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          PRESC_W      = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

    typedef enum logic [2:0] {
        REG_NONE     = 3'd0,
        REG_MSIP     = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_MTIME_LO = 3'd4,
        REG_MTIME_HI = 3'd5
    } reg_sel_e;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    // Exact-match decode: any unaligned or unmapped offset yields REG_NONE.
    function automatic reg_sel_e decode(input logic [15:0] addr);
        reg_sel_e res;
        case (addr)
            ADDR_MSIP:        res = REG_MSIP;
            ADDR_MTIMECMP_LO: res = REG_CMP_LO;
            ADDR_MTIMECMP_HI: res = REG_CMP_HI;
            ADDR_MTIME_LO:    res = REG_MTIME_LO;
            ADDR_MTIME_HI:    res = REG_MTIME_HI;
            default:          res = REG_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/titan_clint_timer.sv
// ---------------------------------------------------------------------------
// titan_clint_timer
// Prescaler, 64-bit mtime counter with byte-masked write port, and the
// registered mtime >= mtimecmp compare that drives the timer interrupt.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   i_we_lo, i_we_hi   write strobes for the mtime low / high word
//   i_wdata, i_sel     write data and byte lane enables
//   i_mtimecmp         current compare value from the bus block
//   o_mtime            current mtime value
//   o_mtip             registered timer interrupt pending
// ---------------------------------------------------------------------------
module titan_clint_timer
    import titan_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_sel,
    input  logic [63:0] i_mtimecmp,
    output logic [63:0] o_mtime,
    output logic        o_mtip
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [63:0]        r_mtime;
    logic [63:0]        w_mtime_nxt;
    logic               r_mtip;
    logic               w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A bus write to either half suppresses the increment for that cycle so
    // the written value lands exactly; the prescaler keeps running.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (i_we_lo || i_we_hi) begin
            if (i_we_lo) begin
                w_mtime_nxt[31:0] = byte_merge(r_mtime[31:0], i_wdata, i_sel);
            end
            if (i_we_hi) begin
                w_mtime_nxt[63:32] = byte_merge(r_mtime[63:32], i_wdata, i_sel);
            end
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime <= MTIME_RST;
            r_mtip  <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nxt;
            r_mtip  <= (r_mtime >= i_mtimecmp);
        end
    end

    assign o_mtime = r_mtime;
    assign o_mtip  = r_mtip;

endmodule

// File: rtl/titan_clint.sv
// ---------------------------------------------------------------------------
// titan_clint
// Machine-level core-local interruptor: Wishbone-classic slave exposing
// msip, mtimecmp and mtime, driving the timer and software interrupts.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   wb_addr_i/dat_i/sel_i/we_i     request address, write data, lanes, write
//   wb_cyc_i, wb_stb_i             bus cycle and strobe
//   wb_dat_o                       registered read data, 0 unless acking
//   wb_ack_o, wb_err_o             one-cycle completion / error pulses
//   xint_mtip_o, xint_msip_o       timer / software interrupt pending
// ---------------------------------------------------------------------------
module titan_clint
    import titan_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] wb_addr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    bus_state_e  r_state;
    bus_state_e  w_state_nxt;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic        w_ack_nxt;
    logic        w_err_nxt;
    logic [31:0] w_dat_nxt;

    logic        r_msip;
    logic [63:0] r_mtimecmp;
    logic [63:0] w_mtime;
    logic        w_mtip;

    logic        w_req;
    reg_sel_e    w_reg;
    logic        w_we_msip;
    logic        w_we_cmp_lo;
    logic        w_we_cmp_hi;
    logic        w_we_mtime_lo;
    logic        w_we_mtime_hi;

    // No new request is taken while a response is on the bus, which makes
    // back-to-back accesses complete every second cycle.
    assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_reg = decode(wb_addr_i);

    always_comb begin
        w_state_nxt   = ST_IDLE;
        w_ack_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_dat_nxt     = '0;
        w_we_msip     = 1'b0;
        w_we_cmp_lo   = 1'b0;
        w_we_cmp_hi   = 1'b0;
        w_we_mtime_lo = 1'b0;
        w_we_mtime_hi = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_RESP;
                    if (w_reg == REG_NONE) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_ack_nxt = 1'b1;
                        if (wb_we_i) begin
                            case (w_reg)
                                REG_MSIP:     w_we_msip     = 1'b1;
                                REG_CMP_LO:   w_we_cmp_lo   = 1'b1;
                                REG_CMP_HI:   w_we_cmp_hi   = 1'b1;
                                REG_MTIME_LO: w_we_mtime_lo = 1'b1;
                                REG_MTIME_HI: w_we_mtime_hi = 1'b1;
                                default:      ;
                            endcase
                        end else begin
                            case (w_reg)
                                REG_MSIP:     w_dat_nxt = {31'd0, r_msip};
                                REG_CMP_LO:   w_dat_nxt = r_mtimecmp[31:0];
                                REG_CMP_HI:   w_dat_nxt = r_mtimecmp[63:32];
                                REG_MTIME_LO: w_dat_nxt = w_mtime[31:0];
                                REG_MTIME_HI: w_dat_nxt = w_mtime[63:32];
                                default:      w_dat_nxt = '0;
                            endcase
                        end
                    end
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    // Register writes commit on the same edge that raises ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= MTIMECMP_RST;
        end else begin
            if (w_we_msip && wb_sel_i[0]) begin
                r_msip <= wb_dat_i[0];
            end
            if (w_we_cmp_lo) begin
                r_mtimecmp[31:0] <= byte_merge(r_mtimecmp[31:0], wb_dat_i, wb_sel_i);
            end
            if (w_we_cmp_hi) begin
                r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], wb_dat_i, wb_sel_i);
            end
        end
    end

    titan_clint_timer #(
        .TICK_DIV  (TICK_DIV),
        .MTIME_RST (MTIME_RST)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_we_lo    (w_we_mtime_lo),
        .i_we_hi    (w_we_mtime_hi),
        .i_wdata    (wb_dat_i),
        .i_sel      (wb_sel_i),
        .i_mtimecmp (r_mtimecmp),
        .o_mtime    (w_mtime),
        .o_mtip     (w_mtip)
    );

    assign wb_dat_o    = r_dat;
    assign wb_ack_o    = r_ack;
    assign wb_err_o    = r_err;
    assign xint_mtip_o = w_mtip;
    assign xint_msip_o = r_msip;

endmodule

// File: tb/tb_titan_clint.sv
// ---------------------------------------------------------------------------
// tb_titan_clint
// Directed bench for titan_clint: table of single accesses plus hand-written
// sequences for timer compare, wrap, back-to-back and reset-in-response.
// ---------------------------------------------------------------------------
module tb_titan_clint;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        mtip;
    logic        msip;

    int total = 0;
    int bad = 0;

    // Values observed by the access task.
    logic        s_ack, s_err, s_mtip_ack, s_msip_ack;
    logic [31:0] s_dat;
    logic        s_ack_end, s_err_end, s_mtip_end;

    always #5 clk = ~clk;

    titan_clint #(
        .TICK_DIV  (1),
        .MTIME_RST (64'h0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb_addr_i   (addr),
        .wb_dat_i    (wdat),
        .wb_sel_i    (sel),
        .wb_we_i     (we),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_dat_o    (rdat),
        .wb_ack_o    (ack),
        .wb_err_o    (err),
        .xint_mtip_o (mtip),
        .xint_msip_o (msip)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_msip;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a clock edge; drives one request, samples the response
    // after the next edge, drops the strobe, and returns #1 after the edge
    // that ends the response.
    task automatic access(input logic [15:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s);
        addr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        s_ack = ack; s_err = err; s_dat = rdat; s_mtip_ack = mtip; s_msip_ack = msip;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        s_ack_end = ack; s_err_end = err; s_mtip_end = mtip;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int first;

        //           addr      we    wdata         sel      ack   err   rdata         msip
        vecs[0]  = '{16'h0000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{16'h4000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{16'h4004, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{16'h4000, 1'b1, 32'h1234_5678, 4'b1111, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{16'h4000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'h1234_5678, 1'b0};
        vecs[5]  = '{16'h4004, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{16'h4004, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'hFFBB_FFDD, 1'b0};
        vecs[7]  = '{16'h0000, 1'b1, 32'h0000_0001, 4'b0001, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{16'h0000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'h0000_0001, 1'b1};
        vecs[9]  = '{16'h0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{16'h0000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'h0000_0001, 1'b1};
        vecs[11] = '{16'h0000, 1'b1, 32'h0000_0000, 4'b0010, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[12] = '{16'h0000, 1'b1, 32'h0000_0000, 4'b0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[13] = '{16'h0000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[14] = '{16'h0002, 1'b0, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[15] = '{16'h1000, 1'b1, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[16] = '{16'h4001, 1'b1, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[17] = '{16'h4000, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 32'h1234_5678, 1'b0};
        vecs[18] = '{16'hBFF4, 1'b0, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_dat", 64'(rdat), 64'd0);
        chk("rst_mtip", 64'(mtip), 64'd0);
        chk("rst_msip", 64'(msip), 64'd0);
        rst_n = 1'b1;

        // Free-running count after reset
        repeat (10) @(posedge clk);
        #1;
        access(16'hBFF8, 1'b0, 32'h0, 4'hF);
        chk("idle_mtime_lo", 64'(s_dat), 64'd10);
        chk("idle_ack", 64'(s_ack), 64'd1);
        chk("idle_mtip", 64'(s_mtip_ack), 64'd0);
        chk("idle_msip", 64'(s_msip_ack), 64'd0);

        // Table of single accesses
        for (int i = 0; i < 19; i++) begin
            access(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].sel);
            chk($sformatf("vec%0d_ack", i), 64'(s_ack), 64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_err", i), 64'(s_err), 64'(vecs[i].exp_err));
            if (!vecs[i].we || vecs[i].exp_err)
                chk($sformatf("vec%0d_dat", i), 64'(s_dat), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_msip", i), 64'(s_msip_ack), 64'(vecs[i].exp_msip));
            chk($sformatf("vec%0d_ack_end", i), 64'(s_ack_end), 64'd0);
            chk($sformatf("vec%0d_err_end", i), 64'(s_err_end), 64'd0);
        end

        // Timer compare: mtime cleared, mtimecmp = 20
        access(16'hBFFC, 1'b1, 32'h0, 4'hF);
        access(16'hBFF8, 1'b1, 32'h0, 4'hF);
        k = 1;
        access(16'h4004, 1'b1, 32'h0, 4'hF);
        access(16'h4000, 1'b1, 32'd20, 4'hF);
        k = k + 4;
        chk("mtip_before", 64'(mtip), 64'd0);
        first = -1;
        for (int i = 0; i < 60 && first < 0; i++) begin
            @(posedge clk); #1;
            k++;
            if (mtip) first = k;
        end
        chk("mtip_rise_cycle", 64'(first), 64'd21);

        // Raising mtimecmp above mtime clears mtip one edge after the commit
        access(16'h4004, 1'b1, 32'h1, 4'hF);
        chk("cmp_hi_mtip_ack", 64'(s_mtip_ack), 64'd1);
        chk("cmp_hi_mtip_end", 64'(s_mtip_end), 64'd0);

        // Wrap of mtime from all ones
        access(16'h4000, 1'b1, 32'hFFFF_FFFF, 4'hF);
        access(16'h4004, 1'b1, 32'hFFFF_FFFF, 4'hF);
        access(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF);
        access(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF);
        chk("wrap_mtip_ack", 64'(s_mtip_ack), 64'd0);
        chk("wrap_mtip_max", 64'(s_mtip_end), 64'd1);
        @(posedge clk); #1;
        chk("wrap_mtip_fall", 64'(mtip), 64'd0);
        access(16'hBFFC, 1'b0, 32'h0, 4'hF);
        chk("wrap_mtime_hi", 64'(s_dat), 64'd0);
        access(16'hBFF8, 1'b0, 32'h0, 4'hF);
        chk("wrap_mtime_lo", 64'(s_dat), 64'd3);

        // Byte-masked mtime write with increment dropped on that cycle
        access(16'hBFF8, 1'b1, 32'h0000_5500, 4'b0010);
        access(16'hBFF8, 1'b0, 32'h0, 4'hF);
        chk("mtime_bytewr", 64'(s_dat), 64'h5506);

        // Back-to-back reads with strobe held high
        addr = 16'h4004; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ack%0d", i), 64'(ack), 64'(i % 2));
            if (i % 2 == 1) chk($sformatf("b2b_dat%0d", i), 64'(rdat), 64'hFFFF_FFFF);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset during the response cycle
        addr = 16'h0000; we = 1'b1; wdat = 32'h1; sel = 4'b0001; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("rresp_ack", 64'(ack), 64'd1);
        chk("rresp_msip", 64'(msip), 64'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rresp_ack_async", 64'(ack), 64'd0);
        chk("rresp_msip_async", 64'(msip), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(16'hBFF8, 1'b0, 32'h0, 4'hF);
        chk("rresp_mtime_lo", 64'(s_dat), 64'd0);
        access(16'hBFFC, 1'b0, 32'h0, 4'hF);
        chk("rresp_mtime_hi", 64'(s_dat), 64'd0);
        access(16'h4000, 1'b0, 32'h0, 4'hF);
        chk("rresp_cmp_lo", 64'(s_dat), 64'hFFFF_FFFF);
        access(16'h4004, 1'b0, 32'h0, 4'hF);
        chk("rresp_cmp_hi", 64'(s_dat), 64'hFFFF_FFFF);
        access(16'h0000, 1'b0, 32'h0, 4'hF);
        chk("rresp_msip_rd", 64'(s_dat), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
